// File: rtl/bcam_table.sv
// Binary/ternary CAM table with per-entry and search-side care masks.
// Two-stage search pipeline: match vector, then priority-encoded result.
module bcam_table #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             inv_en,
  input  logic             srch_en,
  input  logic [WIDTH-1:0] srch_key,
  input  logic [WIDTH-1:0] srch_care,
  output logic             res_valid,
  output logic             res_hit,
  output logic [AW-1:0]    res_addr,
  output logic             res_multi,
  output logic [DEPTH-1:0] res_vec,
  output logic [AW:0]      count,
  output logic             full
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] care_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW:0]      count_q;

  logic [DEPTH-1:0] match_vec;
  logic             s1_valid;
  logic [DEPTH-1:0] s1_vec;

  logic             enc_hit;
  logic [AW-1:0]    enc_addr;
  logic             enc_multi;

  // Compare key against every entry using pre-write table state.
  always_comb begin
    match_vec = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      match_vec[e] = valid_q[e] &&
                     (((data_q[e] ^ srch_key) & care_q[e] & srch_care) == '0);
    end
  end

  // Table storage and valid-entry count; write takes precedence over invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        data_q[e] <= '0;
        care_q[e] <= '0;
      end
    end else if (wr_en) begin
      data_q[wr_addr]  <= wr_data;
      care_q[wr_addr]  <= wr_care;
      valid_q[wr_addr] <= 1'b1;
      if (!valid_q[wr_addr])
        count_q <= count_q + (AW+1)'(1);
    end else if (inv_en) begin
      valid_q[wr_addr] <= 1'b0;
      if (valid_q[wr_addr])
        count_q <= count_q - (AW+1)'(1);
    end
  end

  // Stage 1: capture the raw match vector for an accepted search.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= srch_en;
      if (srch_en)
        s1_vec <= match_vec;
    end
  end

  // Lowest-index priority encode with multi-hit detection.
  always_comb begin
    enc_hit   = 1'b0;
    enc_addr  = '0;
    enc_multi = 1'b0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (s1_vec[e]) begin
        if (enc_hit) begin
          enc_multi = 1'b1;
        end else begin
          enc_hit  = 1'b1;
          enc_addr = AW'(e);
        end
      end
    end
  end

  // Stage 2: register results; they hold between result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_addr  <= '0;
      res_multi <= 1'b0;
      res_vec   <= '0;
    end else begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_hit   <= enc_hit;
        res_addr  <= enc_addr;
        res_multi <= enc_multi;
        res_vec   <= s1_vec;
      end
    end
  end

  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_bcam_table.sv
// Directed self-checking bench for bcam_table (WIDTH=8, DEPTH=16).
module tb_bcam_table;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] wr_care;
  logic             inv_en;
  logic             srch_en;
  logic [WIDTH-1:0] srch_key;
  logic [WIDTH-1:0] srch_care;
  logic             res_valid;
  logic             res_hit;
  logic [AW-1:0]    res_addr;
  logic             res_multi;
  logic [DEPTH-1:0] res_vec;
  logic [AW:0]      count;
  logic             full;

  int unsigned errors;
  int unsigned checks;

  bcam_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_care   (wr_care),
    .inv_en    (inv_en),
    .srch_en   (srch_en),
    .srch_key  (srch_key),
    .srch_care (srch_care),
    .res_valid (res_valid),
    .res_hit   (res_hit),
    .res_addr  (res_addr),
    .res_multi (res_multi),
    .res_vec   (res_vec),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] c);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_care = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_inv(input logic [AW-1:0] a);
    inv_en = 1'b1; wr_addr = a;
    tick();
    inv_en = 1'b0;
  endtask

  // Launch one search and return when its result strobe is due.
  task automatic do_search(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] c);
    srch_en = 1'b1; srch_key = k; srch_care = c;
    tick();
    srch_en = 1'b0;
    chk("lat1_no_valid", 32'(res_valid), 32'd0);
    tick();
  endtask

  task automatic chk_res(input string tag, input logic h, input logic [AW-1:0] a,
                         input logic m, input logic [DEPTH-1:0] v);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_hit"},   32'(res_hit),   32'(h));
    chk({tag, "_addr"},  32'(res_addr),  32'(a));
    chk({tag, "_multi"}, 32'(res_multi), 32'(m));
    chk({tag, "_vec"},   32'(res_vec),   32'(v));
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_care = '0;
    inv_en = 1'b0; srch_en = 1'b0; srch_key = '0; srch_care = '0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_hit",   32'(res_hit),   32'd0);
    chk("rst_addr",  32'(res_addr),  32'd0);
    chk("rst_vec",   32'(res_vec),   32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_full",  32'(full),      32'd0);

    // Basic exact match
    do_write(4'd3, 8'hA5, 8'hFF);
    chk("basic_count", 32'(count), 32'd1);
    do_search(8'hA5, 8'hFF);
    chk_res("basic", 1'b1, 4'd3, 1'b0, 16'h0008);
    tick();
    chk("hold_valid", 32'(res_valid), 32'd0);
    chk("hold_addr",  32'(res_addr),  32'd3);
    chk("hold_hit",   32'(res_hit),   32'd1);

    // Ternary and priority
    do_reset();
    do_write(4'd2, 8'hA0, 8'hF0);
    do_write(4'd7, 8'hA5, 8'hFF);
    do_search(8'hA5, 8'hFF);
    chk_res("tern_a5", 1'b1, 4'd2, 1'b1, 16'h0084);
    do_search(8'hA6, 8'hFF);
    chk_res("tern_a6", 1'b1, 4'd2, 1'b0, 16'h0004);
    do_search(8'h15, 8'hFF);
    chk_res("tern_miss", 1'b0, 4'd0, 1'b0, 16'h0000);
    // Search-side don't-care on the low nibble lets e7 match too
    do_search(8'hAF, 8'hF0);
    chk_res("tern_scare", 1'b1, 4'd2, 1'b1, 16'h0084);

    // Read-before-write
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; wr_care = 8'hFF;
    srch_en = 1'b1; srch_key = 8'h3C; srch_care = 8'hFF;
    tick();
    wr_en = 1'b0; srch_en = 1'b0;
    tick();
    chk_res("rbw_same", 1'b0, 4'd0, 1'b0, 16'h0000);
    do_search(8'h3C, 8'hFF);
    chk_res("rbw_next", 1'b1, 4'd5, 1'b0, 16'h0020);

    // Count / full
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 8'(i), 8'hFF);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full",  32'(full),  32'd1);
    do_write(4'd0, 8'h80, 8'hFF);
    chk("ovw_count", 32'(count), 32'd16);
    do_inv(4'd4);
    chk("inv1_count", 32'(count), 32'd15);
    chk("inv1_full",  32'(full),  32'd0);
    do_inv(4'd4);
    chk("inv2_count", 32'(count), 32'd15);
    do_search(8'h04, 8'hFF);
    chk_res("inv_miss", 1'b0, 4'd0, 1'b0, 16'h0000);
    wr_en = 1'b1; inv_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h04; wr_care = 8'hFF;
    tick();
    wr_en = 1'b0; inv_en = 1'b0;
    chk("wrinv_count", 32'(count), 32'd16);
    chk("wrinv_full",  32'(full),  32'd1);
    do_search(8'h04, 8'hFF);
    chk_res("wrinv_e4", 1'b1, 4'd4, 1'b0, 16'h0010);
    // Zero search care: every valid entry matches
    do_search(8'h5A, 8'h00);
    chk_res("zcare", 1'b1, 4'd0, 1'b1, 16'hFFFF);

    // Back-to-back searches
    do_reset();
    do_write(4'd1, 8'h11, 8'hFF);
    do_write(4'd2, 8'h22, 8'hFF);
    do_write(4'd3, 8'h33, 8'hFF);
    srch_en = 1'b1; srch_care = 8'hFF; srch_key = 8'h11;
    tick();
    chk("b2b_v0", 32'(res_valid), 32'd0);
    srch_key = 8'h22;
    tick();
    chk_res("b2b_11", 1'b1, 4'd1, 1'b0, 16'h0002);
    srch_key = 8'h33;
    tick();
    chk_res("b2b_22", 1'b1, 4'd2, 1'b0, 16'h0004);
    srch_en = 1'b0;
    tick();
    chk_res("b2b_33", 1'b1, 4'd3, 1'b0, 16'h0008);
    tick();
    chk("b2b_end", 32'(res_valid), 32'd0);

    // Reset mid-search
    do_reset();
    do_write(4'd6, 8'h5A, 8'hFF);
    srch_en = 1'b1; srch_key = 8'h5A; srch_care = 8'hFF;
    tick();
    srch_en = 1'b0; rst = 1'b1;
    tick();
    chk("rms_valid0", 32'(res_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rms_valid1", 32'(res_valid), 32'd0);
    chk("rms_count",  32'(count),     32'd0);
    do_search(8'h5A, 8'hFF);
    chk_res("rms_after", 1'b0, 4'd0, 1'b0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcam_table.md
BCAM_TABLE -- requirements
Module: bcam_table

Interface
REQ-001 Parameter WIDTH, default 8, key/entry data width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries (>=2, power of two).
REQ-003 Parameter AW, default $clog2(DEPTH), entry address width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  write entry wr_addr: data, care mask; set valid.
REQ-007 wr_addr  in  AW  write/invalidate target entry.
REQ-008 wr_data  in  WIDTH  stored data.
REQ-009 wr_care  in  WIDTH  stored per-bit care mask; 1=compare, 0=don't-care.
REQ-010 inv_en  in  1  clear valid bit of entry wr_addr.
REQ-011 srch_en  in  1  launch search this cycle.
REQ-012 srch_key  in  WIDTH  search key.
REQ-013 srch_care  in  WIDTH  search-side care mask; 1=compare.
REQ-014 res_valid  out  1  result strobe, one cycle per search.
REQ-015 res_hit  out  1  at least one entry matched.
REQ-016 res_addr  out  AW  lowest-index matching entry; 0 when no hit.
REQ-017 res_multi  out  1  two or more entries matched.
REQ-018 res_vec  out  DEPTH  raw per-entry match vector.
REQ-019 count  out  AW+1  number of valid entries.
REQ-020 full  out  1  count==DEPTH.

Function
REQ-021 Entry e matches iff valid[e] and, for every bit i, (care[e][i] & srch_care[i])==0 or data[e][i]==srch_key[i].
REQ-022 Two-stage pipeline: stage 1 registers the match vector on the srch_en edge; stage 2 registers priority-encoded outputs; res_valid asserts exactly 2 cycles after srch_en; one search accepted per cycle, no stalls.
REQ-023 Search compares against table state before the same-edge write/invalidate (read-before-write).
REQ-024 res_hit/res_addr/res_multi/res_vec update only with res_valid; they hold their last values otherwise.
REQ-025 Priority: lowest index wins; res_multi=1 iff popcount(res_vec)>=2.
REQ-026 wr_en and inv_en same cycle: wr_en wins, inv_en ignored.
REQ-027 count +1 on write to an invalid entry; unchanged on write to a valid entry (overwrite); -1 on inv_en to a valid entry; unchanged on inv_en to an invalid entry.
REQ-028 Write while full is allowed and only overwrites; count stays DEPTH.
REQ-029 Entry with all-zero effective care (wr_care=0 or srch_care=0) matches any key if valid.
REQ-030 No hit: res_hit=0, res_addr=0, res_multi=0, res_vec=0.

Reset
REQ-031 On rst: all valid bits, data, care cleared; count=0; full=0; res_valid=0, res_hit=0, res_addr=0, res_multi=0, res_vec=0; both pipeline stages flushed.
REQ-032 rst overrides wr_en, inv_en, srch_en in the same cycle; searches in flight are dropped (no res_valid for them).
REQ-033 First search is accepted on the cycle after rst deasserts.

Verification
REQ-034 Basic: write e3=0xA5 care=0xFF, search 0xA5 care=0xFF -> 2 cycles later res_valid=1, hit=1, addr=3, multi=0, vec=0x0008.
REQ-035 Ternary/priority: e2=0xA0 care=0xF0, e7=0xA5 care=0xFF, search 0xA5 -> hit=1, addr=2, multi=1, vec=0x0084; search 0xA6 -> addr=2, multi=0.
REQ-036 Read-before-write: write e5=0x3C and search 0x3C on the same edge -> res_hit=0; repeat search next cycle -> hit=1, addr=5.
REQ-037 Count/full: fill all 16 entries -> count=16, full=1; overwrite e0 -> count=16; inv e4 twice -> count=15; wr_en+inv_en on e4 -> count=16, e4 valid.
REQ-038 Back-to-back searches 0x11, 0x22, 0x33 on consecutive cycles -> three consecutive res_valid pulses in order.
REQ-039 Reset mid-search: srch_en then rst next cycle -> no res_valid; count=0; previously stored key searched after reset -> hit=0.
